// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode selectors and pointer-width helper.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_W register file: synchronous write port, asynchronous read port.
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                      i_clk,
    input  logic                      we,
    input  logic [ptr_w(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [ptr_w(DEPTH)-1:0]   raddr,
    output logic [DATA_W-1:0]         rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset; occupancy tracking makes stale words invisible.
    always_ff @(posedge i_clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, flags, error pulses and read-data path.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 16,
    parameter int AFULL_THR  = DEPTH - 2,
    parameter int AEMPTY_THR = 2,
    parameter int FWFT       = FIFO_STD
) (
    input  logic                    i_clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic [DATA_W-1:0]       i_wdata,
    input  logic                    i_wr,
    input  logic                    i_rd,
    output logic [DATA_W-1:0]       o_rdata,
    output logic                    o_wfull,
    output logic                    o_rempty,
    output logic                    o_afull,
    output logic                    o_aempty,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_overflow,
    output logic                    o_underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_THR);
    localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_THR);

    logic [PW-1:0]     wptr, rptr;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] mem_rdata;
    logic              rd_ok, wr_ok;

    assign o_count  = count;
    assign o_wfull  = (count == FULL_CNT);
    assign o_rempty = (count == '0);
    assign o_afull  = (count >= AFULL_CNT);
    assign o_aempty = (count <= AEMPTY_CNT);

    // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
    assign rd_ok = i_rd & ~o_rempty;
    assign wr_ok = i_wr & (~o_wfull | rd_ok);

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (i_clr) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            o_overflow  <= i_wr & ~wr_ok;
            o_underflow <= i_rd & ~rd_ok;
        end
    end

    fifo_mem_2p #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .i_clk (i_clk),
        .we    (wr_ok & ~i_clr),
        .waddr (wptr),
        .wdata (i_wdata),
        .raddr (rptr),
        .rdata (mem_rdata)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            assign o_rdata = o_rempty ? '0 : mem_rdata;
        end else begin : g_std
            logic [DATA_W-1:0] rdata_q;
            always_ff @(posedge i_clk or negedge rst_n) begin
                if (!rst_n)     rdata_q <= '0;
                else if (i_clr) rdata_q <= '0;
                else if (rd_ok) rdata_q <= mem_rdata;
            end
            assign o_rdata = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench: standard and FWFT instances driven in lockstep, checked against a queue model.
module tb_sync_fifo_ctrl;

    localparam int DW = 32;
    localparam int D  = 16;

    logic          i_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_clr = 1'b0;
    logic [DW-1:0] i_wdata = '0;
    logic          i_wr = 1'b0;
    logic          i_rd = 1'b0;

    logic [DW-1:0] s_rdata, f_rdata;
    logic          s_wfull, s_rempty, s_afull, s_aempty, s_ovf, s_udf;
    logic          f_wfull, f_rempty, f_afull, f_aempty, f_ovf, f_udf;
    logic [4:0]    s_count, f_count;

    always #5 i_clk = ~i_clk;

    sync_fifo_ctrl #(.DATA_W(DW), .DEPTH(D), .FWFT(0)) u_std (
        .i_clk(i_clk), .rst_n(rst_n), .i_clr(i_clr), .i_wdata(i_wdata),
        .i_wr(i_wr), .i_rd(i_rd), .o_rdata(s_rdata), .o_wfull(s_wfull),
        .o_rempty(s_rempty), .o_afull(s_afull), .o_aempty(s_aempty),
        .o_count(s_count), .o_overflow(s_ovf), .o_underflow(s_udf)
    );

    sync_fifo_ctrl #(.DATA_W(DW), .DEPTH(D), .FWFT(1)) u_fw (
        .i_clk(i_clk), .rst_n(rst_n), .i_clr(i_clr), .i_wdata(i_wdata),
        .i_wr(i_wr), .i_rd(i_rd), .o_rdata(f_rdata), .o_wfull(f_wfull),
        .o_rempty(f_rempty), .o_afull(f_afull), .o_aempty(f_aempty),
        .o_count(f_count), .o_overflow(f_ovf), .o_underflow(f_udf)
    );

    int nchk = 0;
    int nerr = 0;

    // Reference model: contents as a queue, plus the registered outputs.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rd = '0;
    bit            m_ovf = 0, m_udf = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit c, input bit w, input bit r, input logic [DW-1:0] d);
        bit rok, wok;
        if (c) begin
            q.delete(); m_rd = '0; m_ovf = 0; m_udf = 0;
        end else begin
            rok = r && (q.size() > 0);
            wok = w && (q.size() < D || rok);
            if (rok) m_rd = q.pop_front();
            if (wok) q.push_back(d);
            m_ovf = w && !wok;
            m_udf = r && !rok;
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("std_count",  32'(s_count),  32'(sz));
        chk("fw_count",   32'(f_count),  32'(sz));
        chk("std_wfull",  32'(s_wfull),  32'(sz == D));
        chk("fw_wfull",   32'(f_wfull),  32'(sz == D));
        chk("std_rempty", 32'(s_rempty), 32'(sz == 0));
        chk("fw_rempty",  32'(f_rempty), 32'(sz == 0));
        chk("std_afull",  32'(s_afull),  32'(sz >= D - 2));
        chk("std_aempty", 32'(s_aempty), 32'(sz <= 2));
        chk("fw_afull",   32'(f_afull),  32'(sz >= D - 2));
        chk("fw_aempty",  32'(f_aempty), 32'(sz <= 2));
        chk("std_ovf",    32'(s_ovf),    32'(m_ovf));
        chk("std_udf",    32'(s_udf),    32'(m_udf));
        chk("fw_ovf",     32'(f_ovf),    32'(m_ovf));
        chk("fw_udf",     32'(f_udf),    32'(m_udf));
        chk("std_rdata",  s_rdata,       m_rd);
        chk("fw_rdata",   f_rdata,       (sz > 0) ? q[0] : '0);
    endtask

    task automatic step(input bit c, input bit w, input bit r, input logic [DW-1:0] d);
        i_clr = c; i_wr = w; i_rd = r; i_wdata = d;
        @(posedge i_clk);
        model_edge(c, w, r, d);
        #1;
        check_all();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_std_count"},  32'(s_count),  0);
        chk({tag, "_fw_count"},   32'(f_count),  0);
        chk({tag, "_std_rempty"}, 32'(s_rempty), 1);
        chk({tag, "_std_wfull"},  32'(s_wfull),  0);
        chk({tag, "_std_aempty"}, 32'(s_aempty), 1);
        chk({tag, "_std_afull"},  32'(s_afull),  0);
        chk({tag, "_std_rdata"},  s_rdata,       0);
        chk({tag, "_fw_rdata"},   f_rdata,       0);
        chk({tag, "_std_ovf"},    32'(s_ovf),    0);
        chk({tag, "_std_udf"},    32'(s_udf),    0);
    endtask

    typedef struct {
        bit            clr, wr, rd;
        logic [DW-1:0] wdata;
        int            ecount;
        bit            eovf, eudf;
        logic [DW-1:0] erd_std, erd_fw;
    } vec_t;

    initial begin
        vec_t       tbl[11];
        logic [DW-1:0] got[16];
        logic [DW-1:0] want[16];
        int         ovf_seen;

        tbl[0]  = '{0, 1, 0, 11, 1, 0, 0, 0,  11};
        tbl[1]  = '{0, 1, 0, 22, 2, 0, 0, 0,  11};
        tbl[2]  = '{0, 0, 1, 0,  1, 0, 0, 11, 22};
        tbl[3]  = '{0, 1, 1, 33, 1, 0, 0, 22, 33};
        tbl[4]  = '{0, 0, 1, 0,  0, 0, 0, 33, 0};
        tbl[5]  = '{0, 0, 1, 0,  0, 0, 1, 33, 0};
        tbl[6]  = '{0, 1, 1, 88, 1, 0, 1, 33, 88};
        tbl[7]  = '{0, 0, 1, 0,  0, 0, 0, 88, 0};
        tbl[8]  = '{0, 1, 0, 55, 1, 0, 0, 88, 55};
        tbl[9]  = '{1, 1, 0, 66, 0, 0, 0, 0,  0};
        tbl[10] = '{0, 0, 1, 0,  0, 0, 1, 0,  0};

        #12;
        check_reset("reset");
        @(negedge i_clk);
        rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].clr, tbl[i].wr, tbl[i].rd, tbl[i].wdata);
            chk($sformatf("tbl%0d_count", i), 32'(s_count), 32'(tbl[i].ecount));
            chk($sformatf("tbl%0d_ovf", i),   32'(s_ovf),   32'(tbl[i].eovf));
            chk($sformatf("tbl%0d_udf", i),   32'(s_udf),   32'(tbl[i].eudf));
            chk($sformatf("tbl%0d_rstd", i),  s_rdata,      tbl[i].erd_std);
            chk($sformatf("tbl%0d_rfw", i),   f_rdata,      tbl[i].erd_fw);
        end

        // Fill to full, then hold i_wr for three rejected writes.
        for (int i = 1; i <= 16; i++) step(0, 1, 0, DW'(i));
        chk("fill_wfull", 32'(s_wfull), 1);
        chk("fill_count", 32'(s_count), 16);
        ovf_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, DW'(200 + i));
            if (s_ovf) ovf_seen++;
        end
        chk("ovf_cycles", 32'(ovf_seen), 3);

        // Drain in standard mode; extra read underflows.
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 1, 0);
            chk($sformatf("drain%0d", i), s_rdata, DW'(i));
        end
        chk("drain_rempty", 32'(s_rempty), 1);
        step(0, 0, 1, 0);
        chk("drain_udf", 32'(s_udf), 1);

        // Full with simultaneous read+write.
        for (int i = 1; i <= 16; i++) step(0, 1, 0, DW'(i));
        ovf_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, DW'(97 + i));
            if (s_ovf) ovf_seen++;
            chk("rw_full_count", 32'(s_count), 16);
        end
        chk("rw_full_noovf", 32'(ovf_seen), 0);
        for (int i = 0; i < 13; i++) want[i] = DW'(4 + i);
        for (int i = 0; i < 3; i++)  want[13 + i] = DW'(97 + i);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 0);
            got[i] = s_rdata;
        end
        for (int i = 0; i < 16; i++) chk($sformatf("rw_drain%0d", i), got[i], want[i]);

        // Empty with simultaneous read+write.
        step(0, 1, 1, 88);
        chk("rw_empty_udf", 32'(s_udf), 1);
        chk("rw_empty_count", 32'(s_count), 1);
        step(0, 0, 1, 0);
        chk("rw_empty_read", s_rdata, 88);

        // FWFT show-ahead.
        step(0, 1, 0, 5);
        chk("fwft_show", f_rdata, 5);
        step(0, 0, 1, 0);
        chk("fwft_pop_rdata", f_rdata, 0);
        chk("fwft_pop_rempty", 32'(f_rempty), 1);

        // Flush beats a concurrent write.
        for (int i = 0; i < 10; i++) step(0, 1, 0, DW'(300 + i));
        step(1, 1, 0, 77);
        chk("clr_count", 32'(s_count), 0);
        chk("clr_rempty", 32'(s_rempty), 1);
        chk("clr_ovf", 32'(s_ovf), 0);
        chk("clr_fw_rdata", f_rdata, 0);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 6; i++) step(0, 1, (i > 2), DW'(400 + i));
        i_wr = 1'b1; i_rd = 1'b1; i_wdata = 999;
        @(posedge i_clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        q.delete(); m_rd = '0; m_ovf = 0; m_udf = 0;
        i_wr = 1'b0; i_rd = 1'b0; i_clr = 1'b0;
        @(negedge i_clk);
        rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check_all();

        // Randomised traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            bit c, w, r;
            c = ($urandom_range(0, 99) < 2);
            w = ($urandom_range(0, 99) < ((n / 250) % 2 ? 70 : 40));
            r = ($urandom_range(0, 99) < ((n / 250) % 2 ? 40 : 70));
            step(c, w, r, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
